// File: rtl/snake_pkg.sv
// Shared constants, FSM state type and small arithmetic helpers for the snake game.
package snake_pkg;

   localparam int H_ACTIVE  = 640;
   localparam int V_ACTIVE  = 480;
   localparam int PREY_SIZE = 10;
   localparam int BORDER    = 10;

   // Span of legal top-left offsets once the border and the prey square are removed
   localparam int RANGE_X = H_ACTIVE - 2 * BORDER - PREY_SIZE;
   localparam int RANGE_Y = V_ACTIVE - 2 * BORDER - PREY_SIZE;

   // Screen centre, used at reset and when every retry has been exhausted
   localparam logic [9:0] FALLBACK_X = 10'(H_ACTIVE / 2);
   localparam logic [8:0] FALLBACK_Y = 9'(V_ACTIVE / 2);

   typedef enum logic [2:0] {
      IDLE,
      DRAW,
      CHECK,
      WAIT_FRAME,
      COMMIT,
      ACTIVE
   } prey_state_t;

   // One conditional subtract maps 0..1023 onto 0..RANGE_X-1 because 1024 < 2*RANGE_X
   function automatic logic [9:0] fold_x(input logic [9:0] v);
      return (v >= 10'(RANGE_X)) ? (v - 10'(RANGE_X)) : v;
   endfunction

   // Same trick for 0..511 onto 0..RANGE_Y-1
   function automatic logic [8:0] fold_y(input logic [8:0] v);
      return (v >= 9'(RANGE_Y)) ? (v - 9'(RANGE_Y)) : v;
   endfunction

endpackage

// File: rtl/prey_lfsr.sv
// Free-running 20-bit Galois LFSR, polynomial x^20 + x^17 + 1, shifting right.
module prey_lfsr (
   input  logic        clk_d,
   input  logic        rst,
   input  logic [19:0] seed,
   output logic [19:0] q
);

   localparam logic [19:0] TAPS = 20'h90000;

   logic [19:0] q_q;
   logic [19:0] q_d;

   // Next value: shift right, fold the ejected bit back in at the tap positions
   always_comb begin
      q_d = {1'b0, q_q[19:1]};
      if (q_q[0]) begin
         q_d = q_d ^ TAPS;
      end
      if (q_q == 20'h0) begin
         q_d = 20'h1;
      end
   end

   // State register; a zero seed is replaced so the sequence can never lock up
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         q_q <= (seed == 20'h0) ? 20'h1 : seed;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/prey_spawn_ctrl.sv
// Prey placement sequencer: draws random candidates, rejects overlaps and repeats,
// and only moves the prey on a frame tick so the renderer never tears.
module prey_spawn_ctrl
   import snake_pkg::*;
#(
   parameter int unsigned MAX_RETRY = 7,
   parameter logic [19:0] LFSR_SEED = 20'h5A5A5
) (
   input  logic       clk_d,
   input  logic       rst,
   input  logic       start,
   input  logic       good_collision,
   input  logic       updateclock,
   input  logic [9:0] head_x,
   input  logic [8:0] head_y,
   output logic [9:0] prey_x,
   output logic [8:0] prey_y,
   output logic       prey_valid,
   output logic [7:0] spawn_count,
   output logic       busy
);

   prey_state_t state_q, state_d;
   logic [9:0]  cand_x_q, cand_x_d;
   logic [8:0]  cand_y_q, cand_y_d;
   logic [7:0]  retry_q, retry_d;
   logic [9:0]  prey_x_q, prey_x_d;
   logic [8:0]  prey_y_q, prey_y_d;
   logic        valid_q, valid_d;
   logic [7:0]  count_q, count_d;

   logic [19:0] lfsr;
   logic        lfsr_unused;
   logic [9:0]  draw_x;
   logic [8:0]  draw_y;
   logic signed [10:0] dx, dy, adx, ady;
   logic        head_hit;
   logic        same_spot;
   logic        reject;

   prey_lfsr u_lfsr (
      .clk_d (clk_d),
      .rst   (rst),
      .seed  (LFSR_SEED),
      .q     (lfsr)
   );

   // Bit 19 only feeds the LFSR itself; the candidate uses the low 19 bits
   assign lfsr_unused = lfsr[19];

   // Candidate generation and the overlap/repeat test on the latched candidate
   always_comb begin
      draw_x    = 10'(BORDER) + fold_x(lfsr[9:0]);
      draw_y    = 9'(BORDER) + fold_y(lfsr[18:10]);
      dx        = $signed({1'b0, cand_x_q}) - $signed({1'b0, head_x});
      dy        = $signed({2'b00, cand_y_q}) - $signed({2'b00, head_y});
      adx       = (dx < 11'sd0) ? -dx : dx;
      ady       = (dy < 11'sd0) ? -dy : dy;
      head_hit  = (adx < $signed(11'(PREY_SIZE))) && (ady < $signed(11'(PREY_SIZE)));
      same_spot = (cand_x_q == prey_x_q) && (cand_y_q == prey_y_q);
      reject    = head_hit || same_spot;
   end

   // Next-state and register-update logic; start low overrides everything
   always_comb begin
      state_d  = state_q;
      cand_x_d = cand_x_q;
      cand_y_d = cand_y_q;
      retry_d  = retry_q;
      prey_x_d = prey_x_q;
      prey_y_d = prey_y_q;
      valid_d  = valid_q;
      count_d  = count_q;
      busy     = 1'b0;

      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            count_d = 8'd0;
            retry_d = 8'd0;
            if (start) begin
               state_d = DRAW;
            end
         end
         DRAW: begin
            busy     = 1'b1;
            cand_x_d = draw_x;
            cand_y_d = draw_y;
            state_d  = CHECK;
         end
         CHECK: begin
            busy = 1'b1;
            if (!reject) begin
               state_d = WAIT_FRAME;
            end else if (retry_q == 8'(MAX_RETRY)) begin
               cand_x_d = FALLBACK_X;
               cand_y_d = FALLBACK_Y;
               state_d  = WAIT_FRAME;
            end else begin
               retry_d = retry_q + 8'd1;
               state_d = DRAW;
            end
         end
         WAIT_FRAME: begin
            busy = 1'b1;
            if (updateclock) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            busy     = 1'b1;
            prey_x_d = cand_x_q;
            prey_y_d = cand_y_q;
            valid_d  = 1'b1;
            count_d  = (count_q == 8'hFF) ? count_q : (count_q + 8'd1);
            retry_d  = 8'd0;
            state_d  = ACTIVE;
         end
         ACTIVE: begin
            if (good_collision) begin
               valid_d = 1'b0;
               state_d = DRAW;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (!start) begin
         state_d = IDLE;
         valid_d = 1'b0;
         count_d = 8'd0;
         retry_d = 8'd0;
      end
   end

   // State and output registers; reset discards any pending candidate
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cand_x_q <= FALLBACK_X;
         cand_y_q <= FALLBACK_Y;
         retry_q  <= 8'd0;
         prey_x_q <= FALLBACK_X;
         prey_y_q <= FALLBACK_Y;
         valid_q  <= 1'b0;
         count_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         cand_x_q <= cand_x_d;
         cand_y_q <= cand_y_d;
         retry_q  <= retry_d;
         prey_x_q <= prey_x_d;
         prey_y_q <= prey_y_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
      end
   end

   assign prey_x      = prey_x_q;
   assign prey_y      = prey_y_q;
   assign prey_valid  = valid_q;
   assign spawn_count = count_q;

endmodule

// File: tb/tb_prey_spawn_ctrl.sv
// Directed bench for prey_spawn_ctrl with an LFSR reference and a candidate predictor.
module tb_prey_spawn_ctrl;

   localparam logic [19:0] SEED = 20'h5A5A5;

   logic       clk_d = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       good_collision = 1'b0;
   logic       updateclock = 1'b0;
   logic [9:0] head_x = 10'd0;
   logic [8:0] head_y = 9'd0;

   logic [9:0] prey_x, fb_prey_x;
   logic [8:0] prey_y, fb_prey_y;
   logic       prey_valid, fb_prey_valid;
   logic [7:0] spawn_count, fb_spawn_count;
   logic       busy, fb_busy;

   int vec_count = 0;
   int miss_count = 0;
   int exp_px, exp_py;

   logic [19:0] mdl;

   prey_spawn_ctrl #(.MAX_RETRY(7), .LFSR_SEED(SEED)) dut (
      .clk_d(clk_d), .rst(rst), .start(start), .good_collision(good_collision),
      .updateclock(updateclock), .head_x(head_x), .head_y(head_y),
      .prey_x(prey_x), .prey_y(prey_y), .prey_valid(prey_valid),
      .spawn_count(spawn_count), .busy(busy)
   );

   prey_spawn_ctrl #(.MAX_RETRY(0), .LFSR_SEED(SEED)) dut_fb (
      .clk_d(clk_d), .rst(rst), .start(start), .good_collision(good_collision),
      .updateclock(updateclock), .head_x(head_x), .head_y(head_y),
      .prey_x(fb_prey_x), .prey_y(fb_prey_y), .prey_valid(fb_prey_valid),
      .spawn_count(fb_spawn_count), .busy(fb_busy)
   );

   always #5 clk_d = ~clk_d;

   // Reference Galois step for x^20 + x^17 + 1
   function automatic logic [19:0] lfsr_step(input logic [19:0] v);
      logic [19:0] n;
      n = v >> 1;
      if (v[0]) begin
         n[19] = ~n[19];
         n[16] = ~n[16];
      end
      return n;
   endfunction

   // Reference LFSR that free-runs alongside the design
   always @(posedge clk_d or posedge rst) begin
      if (rst) mdl <= SEED;
      else     mdl <= lfsr_step(mdl);
   end

   function automatic void cand_of(input logic [19:0] v, output int cx, output int cy);
      cx = int'(v[9:0]);
      if (cx >= 610) cx = cx - 610;
      cx = cx + 10;
      cy = int'(v[18:10]);
      if (cy >= 450) cy = cy - 450;
      cy = cy + 10;
   endfunction

   function automatic int iabs(input int a);
      return (a < 0) ? -a : a;
   endfunction

   // Predicts the committed spot given the reference LFSR value one edge before the draw
   function automatic void predict(input logic [19:0] m0, input int hx, input int hy,
                                   input int px, input int py, input int maxr,
                                   output int ex, output int ey, output int nretry);
      logic [19:0] v;
      int cx, cy;
      v = lfsr_step(m0);
      ex = 320;
      ey = 240;
      nretry = 0;
      for (int k = 0; k <= maxr; k++) begin
         cand_of(v, cx, cy);
         if (!((iabs(cx - hx) < 10 && iabs(cy - hy) < 10) || (cx == px && cy == py))) begin
            ex = cx;
            ey = cy;
            return;
         end
         if (k == maxr) return;
         nretry = nretry + 1;
         v = lfsr_step(lfsr_step(v));
      end
   endfunction

   task automatic do_reset();
      @(negedge clk_d);
      rst = 1'b1;
      start = 1'b0;
      good_collision = 1'b0;
      updateclock = 1'b0;
      @(negedge clk_d);
      rst = 1'b0;
      @(negedge clk_d);
   endtask

   // Holds the frame tick until the main instance shows a committed prey (bounded)
   task automatic finish_spawn(output bit ok);
      ok = 1'b0;
      updateclock = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_d);
         if (prey_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      updateclock = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vec_count += 5;
      if (prey_x !== 10'd320) begin miss_count++; $display("[TB] FAIL reset_prey_x: got %0d expected 320", prey_x); end
      if (prey_y !== 9'd240) begin miss_count++; $display("[TB] FAIL reset_prey_y: got %0d expected 240", prey_y); end
      if (prey_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_valid: got %b expected 0", prey_valid); end
      if (spawn_count !== 8'd0) begin miss_count++; $display("[TB] FAIL reset_count: got %0d expected 0", spawn_count); end
      if (busy !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_spawn();
      int ex, ey, nr;
      head_x = 10'd0;
      head_y = 9'd0;
      predict(mdl, 0, 0, 320, 240, 7, ex, ey, nr);
      start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_d);
         if (i == 9) begin
            vec_count += 2;
            if (busy !== 1'b1) begin miss_count++; $display("[TB] FAIL spawn_wait_busy: got %b expected 1", busy); end
            if (prey_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL spawn_wait_valid: got %b expected 0", prey_valid); end
         end
      end
      updateclock = 1'b1;
      @(negedge clk_d);
      updateclock = 1'b0;
      vec_count += 1;
      if (prey_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL spawn_commit_valid: got %b expected 0", prey_valid); end
      @(negedge clk_d);
      vec_count += 7;
      if (prey_valid !== 1'b1) begin miss_count++; $display("[TB] FAIL spawn_valid: got %b expected 1", prey_valid); end
      if (spawn_count !== 8'd1) begin miss_count++; $display("[TB] FAIL spawn_count: got %0d expected 1", spawn_count); end
      if (busy !== 1'b0) begin miss_count++; $display("[TB] FAIL spawn_busy: got %b expected 0", busy); end
      if (int'(prey_x) != ex) begin miss_count++; $display("[TB] FAIL spawn_x: got %0d expected %0d", prey_x, ex); end
      if (int'(prey_y) != ey) begin miss_count++; $display("[TB] FAIL spawn_y: got %0d expected %0d", prey_y, ey); end
      if (prey_x < 10'd10 || prey_x > 10'd619) begin miss_count++; $display("[TB] FAIL spawn_x_range: got %0d expected 10..619", prey_x); end
      if (prey_y < 9'd10 || prey_y > 9'd459) begin miss_count++; $display("[TB] FAIL spawn_y_range: got %0d expected 10..459", prey_y); end
      exp_px = ex;
      exp_py = ey;
   endtask

   task automatic test_eat();
      int ex, ey, nr, old_x, old_y;
      bit ok;
      old_x = exp_px;
      old_y = exp_py;
      predict(mdl, 0, 0, old_x, old_y, 7, ex, ey, nr);
      good_collision = 1'b1;
      @(negedge clk_d);
      good_collision = 1'b0;
      vec_count += 3;
      if (prey_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL eat_valid_low: got %b expected 0", prey_valid); end
      if (busy !== 1'b1) begin miss_count++; $display("[TB] FAIL eat_busy: got %b expected 1", busy); end
      if (spawn_count !== 8'd1) begin miss_count++; $display("[TB] FAIL eat_count_hold: got %0d expected 1", spawn_count); end
      finish_spawn(ok);
      vec_count += 5;
      if (!ok) begin miss_count++; $display("[TB] FAIL eat_timeout: got valid %b expected 1", prey_valid); end
      if (int'(prey_x) != ex) begin miss_count++; $display("[TB] FAIL eat_x: got %0d expected %0d", prey_x, ex); end
      if (int'(prey_y) != ey) begin miss_count++; $display("[TB] FAIL eat_y: got %0d expected %0d", prey_y, ey); end
      if (int'(prey_x) == old_x && int'(prey_y) == old_y) begin miss_count++; $display("[TB] FAIL eat_moved: got (%0d,%0d) expected a new spot", prey_x, prey_y); end
      if (spawn_count !== 8'd2) begin miss_count++; $display("[TB] FAIL eat_count: got %0d expected 2", spawn_count); end
      exp_px = ex;
      exp_py = ey;
   endtask

   task automatic test_reject();
      int c1x, c1y, ex, ey, nr;
      bit ok;
      do_reset();
      cand_of(lfsr_step(mdl), c1x, c1y);
      head_x = 10'(c1x);
      head_y = 9'(c1y);
      predict(mdl, c1x, c1y, 320, 240, 7, ex, ey, nr);
      if (nr < 1) $display("[TB] note: reject scenario produced no retry");
      start = 1'b1;
      finish_spawn(ok);
      vec_count += 5;
      if (!ok) begin miss_count++; $display("[TB] FAIL reject_timeout: got valid %b expected 1", prey_valid); end
      if (int'(prey_x) != ex) begin miss_count++; $display("[TB] FAIL reject_x: got %0d expected %0d", prey_x, ex); end
      if (int'(prey_y) != ey) begin miss_count++; $display("[TB] FAIL reject_y: got %0d expected %0d", prey_y, ey); end
      if (iabs(int'(prey_x) - c1x) < 10 && iabs(int'(prey_y) - c1y) < 10) begin
         miss_count++;
         $display("[TB] FAIL reject_disjoint: got (%0d,%0d) expected clear of head (%0d,%0d)", prey_x, prey_y, c1x, c1y);
      end
      if (spawn_count !== 8'd1) begin miss_count++; $display("[TB] FAIL reject_count: got %0d expected 1", spawn_count); end
   endtask

   task automatic test_fallback();
      int c1x, c1y;
      do_reset();
      cand_of(lfsr_step(mdl), c1x, c1y);
      head_x = 10'(c1x);
      head_y = 9'(c1y);
      start = 1'b1;
      repeat (3) @(negedge clk_d);
      vec_count += 2;
      if (fb_busy !== 1'b1) begin miss_count++; $display("[TB] FAIL fallback_busy: got %b expected 1", fb_busy); end
      if (fb_prey_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL fallback_wait_valid: got %b expected 0", fb_prey_valid); end
      updateclock = 1'b1;
      @(negedge clk_d);
      updateclock = 1'b0;
      @(negedge clk_d);
      vec_count += 4;
      if (fb_prey_valid !== 1'b1) begin miss_count++; $display("[TB] FAIL fallback_valid: got %b expected 1", fb_prey_valid); end
      if (fb_prey_x !== 10'd320) begin miss_count++; $display("[TB] FAIL fallback_x: got %0d expected 320", fb_prey_x); end
      if (fb_prey_y !== 9'd240) begin miss_count++; $display("[TB] FAIL fallback_y: got %0d expected 240", fb_prey_y); end
      if (fb_spawn_count !== 8'd1) begin miss_count++; $display("[TB] FAIL fallback_count: got %0d expected 1", fb_spawn_count); end
      head_x = 10'd0;
      head_y = 9'd0;
   endtask

   task automatic test_saturation();
      bit ok;
      do_reset();
      head_x = 10'd0;
      head_y = 9'd0;
      start = 1'b1;
      finish_spawn(ok);
      vec_count += 1;
      if (!ok) begin miss_count++; $display("[TB] FAIL sat_first_timeout: got valid %b expected 1", prey_valid); end
      for (int n = 0; n < 300; n++) begin
         good_collision = 1'b1;
         @(negedge clk_d);
         good_collision = 1'b0;
         finish_spawn(ok);
         vec_count += 1;
         if (!ok) begin miss_count++; $display("[TB] FAIL sat_spawn_timeout: got valid %b expected 1 at spawn %0d", prey_valid, n); end
         if (n == 98) begin
            vec_count += 1;
            if (spawn_count !== 8'd100) begin miss_count++; $display("[TB] FAIL sat_count_100: got %0d expected 100", spawn_count); end
         end
      end
      vec_count += 1;
      if (spawn_count !== 8'd255) begin miss_count++; $display("[TB] FAIL sat_count: got %0d expected 255", spawn_count); end
   endtask

   task automatic test_stop_in_wait();
      logic [9:0] keep_x;
      logic [8:0] keep_y;
      keep_x = prey_x;
      keep_y = prey_y;
      good_collision = 1'b1;
      @(negedge clk_d);
      good_collision = 1'b0;
      repeat (2) @(negedge clk_d);
      vec_count += 1;
      if (busy !== 1'b1) begin miss_count++; $display("[TB] FAIL stop_pre_busy: got %b expected 1", busy); end
      start = 1'b0;
      @(negedge clk_d);
      vec_count += 5;
      if (prey_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL stop_valid: got %b expected 0", prey_valid); end
      if (spawn_count !== 8'd0) begin miss_count++; $display("[TB] FAIL stop_count: got %0d expected 0", spawn_count); end
      if (busy !== 1'b0) begin miss_count++; $display("[TB] FAIL stop_busy: got %b expected 0", busy); end
      if (prey_x !== keep_x) begin miss_count++; $display("[TB] FAIL stop_keep_x: got %0d expected %0d", prey_x, keep_x); end
      if (prey_y !== keep_y) begin miss_count++; $display("[TB] FAIL stop_keep_y: got %0d expected %0d", prey_y, keep_y); end
   endtask

   task automatic test_collision_and_tick();
      int ex, ey, nr;
      bit ok;
      do_reset();
      head_x = 10'd0;
      head_y = 9'd0;
      predict(mdl, 0, 0, 320, 240, 7, ex, ey, nr);
      start = 1'b1;
      finish_spawn(ok);
      exp_px = ex;
      exp_py = ey;
      predict(mdl, 0, 0, exp_px, exp_py, 7, ex, ey, nr);
      good_collision = 1'b1;
      updateclock = 1'b1;
      @(negedge clk_d);
      good_collision = 1'b0;
      updateclock = 1'b0;
      vec_count += 3;
      if (prey_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL both_valid: got %b expected 0", prey_valid); end
      if (busy !== 1'b1) begin miss_count++; $display("[TB] FAIL both_busy: got %b expected 1", busy); end
      if (spawn_count !== 8'd1) begin miss_count++; $display("[TB] FAIL both_count: got %0d expected 1", spawn_count); end
      repeat (3) @(negedge clk_d);
      vec_count += 2;
      if (prey_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL both_no_commit: got %b expected 0", prey_valid); end
      if (spawn_count !== 8'd1) begin miss_count++; $display("[TB] FAIL both_count_hold: got %0d expected 1", spawn_count); end
      finish_spawn(ok);
      vec_count += 4;
      if (!ok) begin miss_count++; $display("[TB] FAIL both_timeout: got valid %b expected 1", prey_valid); end
      if (spawn_count !== 8'd2) begin miss_count++; $display("[TB] FAIL both_count_after: got %0d expected 2", spawn_count); end
      if (int'(prey_x) != ex) begin miss_count++; $display("[TB] FAIL both_x: got %0d expected %0d", prey_x, ex); end
      if (int'(prey_y) != ey) begin miss_count++; $display("[TB] FAIL both_y: got %0d expected %0d", prey_y, ey); end
   endtask

   // Guard against a stuck run
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no completion expected finish before 2ms");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_spawn();
      test_eat();
      test_reject();
      test_fallback();
      test_saturation();
      test_stop_in_wait();
      test_collision_and_tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
